note_player: RTL and testbench
==============================

// Module: note_player
// PURPOSE
//  Sequences the piano tone generator: arbitrates between live keys and a note-sequence
//  stream, and drives an internal programmable half-period divider on the 100 MHz clock.
//  Live keys always win. Sequence notes play for a beat count, then a fixed silent gap.
//  Sits between the key debouncer / song ROM reader and the board buzzer pin.
// PARAMETERS
//  BEAT_CYCLES  25_000_000  clk cycles per beat (250 ms)
//  GAP_CYCLES   2_500_000   silent clk cycles after each sequence note (25 ms)
//  DIV_SHIFT    0           right-shift applied to every half-period table entry (sim speed-up)
// PORTS
//  clk_100mhz  in   1  system clock, 100 MHz
//  rst_n       in   1  asynchronous active-low reset
//  key         in   7  live keys C4..B4 (bit0=C), active-high, debounced/synchronous upstream
//  seq_valid   in   1  sequence note offered
//  seq_note    in   3  0=rest, 1..7=C4..B4
//  seq_beats   in   4  note length in beats
//  seq_ready   out  1  block accepts the sequence note this cycle
//  seq_abort   out  1  1-cycle pulse: accepted sequence note preempted by a key
//  buzzer      out  1  square-wave tone output
//  busy        out  1  state != IDLE
//  cur_note    out  3  note currently driven (0 = silent)
// BEHAVIOUR
//  Reset: state=IDLE; seq_ready=0; seq_abort=0; buzzer=0; busy=0; cur_note=0; all counters 0.
//  Half-period table HALF[n] >> DIV_SHIFT, clk cycles: C 191113, D 170265, E 151686, F 143173,
//   G 127551, A 113636, B 101239. Divider counter is 18 bits.
//  Divider:
//   - cur_note!=0: cnt increments; at cnt==HALF-1, buzzer toggles and cnt<=0.
//   - cur_note==0: buzzer held 0, cnt held 0.
//   - Any change of cur_note: same edge sets cnt<=0 and buzzer<=0 (phase restart).
//  Key select: lowest set bit of key wins; kidx = bit index + 1.
//  seq_ready is combinational: state==IDLE && key==0. Handshake completes on seq_valid & seq_ready.
//  FSM (all transitions on clk edge):
//   IDLE:
//    - key!=0 -> KEY, cur_note<=kidx.
//    - else handshake -> SEQ, cur_note<=seq_note, beat_cnt<=0, beats<=seq_beats;
//      seq_beats==0 -> GAP directly, cur_note<=0.
//   KEY:
//    - key==0 -> IDLE, cur_note<=0.
//    - else cur_note<=kidx; a new kidx restarts the divider phase.
//   SEQ (cur_note held):
//    - key!=0 -> KEY, cur_note<=kidx, seq_abort=1 for 1 cycle; note dropped, no gap.
//    - elapsed==beats*BEAT_CYCLES cycles -> GAP, cur_note<=0, gap_cnt<=0.
//   GAP:
//    - key!=0 -> KEY, no abort pulse.
//    - after GAP_CYCLES cycles -> IDLE.
//  Timing: note accepted at edge T plays exactly beats*BEAT_CYCLES cycles (T..T+N-1),
//   is silent for GAP_CYCLES cycles, then seq_ready may rise on the next cycle.
//  Rest note (seq_note=0): same timing, buzzer stays 0.
//  Counters saturate nowhere; beats*BEAT_CYCLES is computed in 32 bits (max 15*2^28 fits).
//  Simultaneous events:
//   - key press and seq_valid in IDLE: key wins, seq_ready=0, no handshake.
//   - key release and seq_valid on the same cycle: IDLE is first entered the next cycle.
//  Reset asserted mid-note: immediate return to reset values; the in-flight note is lost, no abort pulse.
// TESTING (BEAT_CYCLES=100, GAP_CYCLES=10, DIV_SHIFT=10)
//  1. Reset, hold key=0x20 (A) -> cur_note=6, buzzer toggles every 110 cycles; key=0 -> buzzer=0, busy=0 next cycle.
//  2. key=0x05 -> cur_note=1 (C), toggle every 186 cycles; change to 0x04 -> cur_note=3, cnt/buzzer restart same edge.
//  3. Sequence E,beats=2 then G,beats=1 -> E for 200 cycles, 10 silent, ready again, G for 100 cycles, 10 silent.
//  4. Sequence B,beats=3; press key bit0 at cycle 50 -> seq_abort single pulse, cur_note=1, no gap; release -> IDLE.
//  5. seq_beats=0 and rest note, beats=1 -> first gives 10-cycle GAP only; second 100 cycles with buzzer=0.
//  6. rst_n low mid-SEQ for 3 cycles -> all outputs 0 asynchronously; next handshake after release behaves per test 3.

Source files
------------

// File: rtl/note_player.sv
// Piano tone sequencer: live keys preempt a handshaked note stream, and the chosen
// note drives a programmable half-period divider that toggles the buzzer pin.
module note_player #(
   parameter int BEAT_CYCLES = 25_000_000,
   parameter int GAP_CYCLES  = 2_500_000,
   parameter int DIV_SHIFT   = 0
) (
   input  logic       clk_100mhz,
   input  logic       rst_n,
   input  logic [6:0] key,
   input  logic       seq_valid,
   input  logic [2:0] seq_note,
   input  logic [3:0] seq_beats,
   output logic       seq_ready,
   output logic       seq_abort,
   output logic       buzzer,
   output logic       busy,
   output logic [2:0] cur_note
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_KEY  = 2'd1;
   localparam logic [1:0] ST_SEQ  = 2'd2;
   localparam logic [1:0] ST_GAP  = 2'd3;

   localparam logic [17:0] HALF_C = 18'(191113 >> DIV_SHIFT);
   localparam logic [17:0] HALF_D = 18'(170265 >> DIV_SHIFT);
   localparam logic [17:0] HALF_E = 18'(151686 >> DIV_SHIFT);
   localparam logic [17:0] HALF_F = 18'(143173 >> DIV_SHIFT);
   localparam logic [17:0] HALF_G = 18'(127551 >> DIV_SHIFT);
   localparam logic [17:0] HALF_A = 18'(113636 >> DIV_SHIFT);
   localparam logic [17:0] HALF_B = 18'(101239 >> DIV_SHIFT);
   localparam logic [31:0] GAP_LAST = 32'(GAP_CYCLES - 1);

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [2:0]  cur_note_nxt;
   logic [2:0]  kidx;
   logic        start_seq;
   logic        start_gap;
   logic        abort_nxt;
   logic [3:0]  beats;
   logic [31:0] beat_cnt;
   logic [31:0] play_len;
   logic [31:0] gap_cnt;
   logic [17:0] div_cnt;
   logic [17:0] half;

   // Lowest-numbered pressed key wins; scan downward so bit 0 overrides last.
   always_comb begin
      kidx = 3'd0;
      for (int i = 6; i >= 0; i--) begin
         if (key[i]) kidx = 3'(i + 1);
      end
   end

   assign play_len  = 32'(beats) * 32'(BEAT_CYCLES);
   assign seq_ready = rst_n && (state == ST_IDLE) && (key == 7'd0);
   assign busy      = (state != ST_IDLE);

   always_comb begin
      state_nxt    = state;
      cur_note_nxt = cur_note;
      start_seq    = 1'b0;
      start_gap    = 1'b0;
      abort_nxt    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (key != 7'd0) begin
               state_nxt    = ST_KEY;
               cur_note_nxt = kidx;
            end else if (seq_valid) begin
               if (seq_beats == 4'd0) begin
                  state_nxt    = ST_GAP;
                  cur_note_nxt = 3'd0;
                  start_gap    = 1'b1;
               end else begin
                  state_nxt    = ST_SEQ;
                  cur_note_nxt = seq_note;
                  start_seq    = 1'b1;
               end
            end
         end
         ST_KEY: begin
            if (key == 7'd0) begin
               state_nxt    = ST_IDLE;
               cur_note_nxt = 3'd0;
            end else begin
               cur_note_nxt = kidx;
            end
         end
         ST_SEQ: begin
            if (key != 7'd0) begin
               state_nxt    = ST_KEY;
               cur_note_nxt = kidx;
               abort_nxt    = 1'b1;
            end else if (beat_cnt == play_len - 32'd1) begin
               state_nxt    = ST_GAP;
               cur_note_nxt = 3'd0;
               start_gap    = 1'b1;
            end
         end
         ST_GAP: begin
            if (key != 7'd0) begin
               state_nxt    = ST_KEY;
               cur_note_nxt = kidx;
            end else if (gap_cnt == GAP_LAST) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt    = ST_IDLE;
            cur_note_nxt = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cur_note  <= 3'd0;
         seq_abort <= 1'b0;
         beats     <= 4'd0;
         beat_cnt  <= 32'd0;
         gap_cnt   <= 32'd0;
      end else begin
         state     <= state_nxt;
         cur_note  <= cur_note_nxt;
         seq_abort <= abort_nxt;
         if (start_seq) begin
            beat_cnt <= 32'd0;
            beats    <= seq_beats;
         end else if (state == ST_SEQ) begin
            beat_cnt <= beat_cnt + 32'd1;
         end
         if (start_gap) begin
            gap_cnt <= 32'd0;
         end else if (state == ST_GAP) begin
            gap_cnt <= gap_cnt + 32'd1;
         end
      end
   end

   always_comb begin
      half = 18'd0;
      case (cur_note)
         3'd1:    half = HALF_C;
         3'd2:    half = HALF_D;
         3'd3:    half = HALF_E;
         3'd4:    half = HALF_F;
         3'd5:    half = HALF_G;
         3'd6:    half = HALF_A;
         3'd7:    half = HALF_B;
         default: half = 18'd0;
      endcase
   end

   // A note change restarts the square wave from a low phase on the same edge.
   always_ff @(posedge clk_100mhz or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= 18'd0;
         buzzer  <= 1'b0;
      end else if ((cur_note_nxt != cur_note) || (cur_note == 3'd0)) begin
         div_cnt <= 18'd0;
         buzzer  <= 1'b0;
      end else if (div_cnt == half - 18'd1) begin
         div_cnt <= 18'd0;
         buzzer  <= ~buzzer;
      end else begin
         div_cnt <= div_cnt + 18'd1;
      end
   end

endmodule

// File: tb/tb_note_player.sv
// Randomized bench for note_player, compared cycle by cycle against a
// behavioural model built from note ages and remaining play/gap time.
module tb_note_player;

   localparam int BEAT  = 100;
   localparam int GAP   = 10;
   localparam int SHIFT = 10;

   localparam int M_IDLE = 0;
   localparam int M_KEY  = 1;
   localparam int M_PLAY = 2;
   localparam int M_GAP  = 3;

   logic       clk_100mhz = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] key = 7'd0;
   logic       seq_valid = 1'b0;
   logic [2:0] seq_note = 3'd0;
   logic [3:0] seq_beats = 4'd0;
   logic       seq_ready;
   logic       seq_abort;
   logic       buzzer;
   logic       busy;
   logic [2:0] cur_note;

   int checks = 0;
   int failures = 0;

   int m_mode = M_IDLE;
   int m_note = 0;
   int m_age = 0;
   int m_play_left = 0;
   int m_gap_left = 0;
   int m_abort = 0;

   note_player #(
      .BEAT_CYCLES(BEAT),
      .GAP_CYCLES(GAP),
      .DIV_SHIFT(SHIFT)
   ) dut (
      .clk_100mhz(clk_100mhz),
      .rst_n(rst_n),
      .key(key),
      .seq_valid(seq_valid),
      .seq_note(seq_note),
      .seq_beats(seq_beats),
      .seq_ready(seq_ready),
      .seq_abort(seq_abort),
      .buzzer(buzzer),
      .busy(busy),
      .cur_note(cur_note)
   );

   always #5 clk_100mhz = ~clk_100mhz;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, observed, expected);
      end
   endtask

   function automatic int lowestKey(input logic [6:0] k);
      for (int i = 0; i < 7; i++) begin
         if (k[i]) return i + 1;
      end
      return 0;
   endfunction

   function automatic int halfOf(input int n);
      int raw;
      case (n)
         1: raw = 191113;
         2: raw = 170265;
         3: raw = 151686;
         4: raw = 143173;
         5: raw = 127551;
         6: raw = 113636;
         7: raw = 101239;
         default: raw = 0;
      endcase
      return raw >> SHIFT;
   endfunction

   function automatic int expectedBuzzer();
      if (m_note == 0) return 0;
      return (m_age / halfOf(m_note)) % 2;
   endfunction

   // One clock edge of the reference: keys preempt, sequence notes play for
   // beats*BEAT cycles, then GAP silent cycles; note age drives the waveform.
   task automatic modelStep();
      int k;
      int nn;
      k = lowestKey(key);
      nn = m_note;
      m_abort = 0;
      case (m_mode)
         M_IDLE: begin
            if (k != 0) begin
               m_mode = M_KEY;
               nn = k;
            end else if (seq_valid) begin
               if (seq_beats == 4'd0) begin
                  m_mode = M_GAP;
                  m_gap_left = GAP;
                  nn = 0;
               end else begin
                  m_mode = M_PLAY;
                  m_play_left = int'(seq_beats) * BEAT;
                  nn = int'(seq_note);
               end
            end
         end
         M_KEY: begin
            if (k == 0) begin
               m_mode = M_IDLE;
               nn = 0;
            end else begin
               nn = k;
            end
         end
         M_PLAY: begin
            if (k != 0) begin
               m_mode = M_KEY;
               nn = k;
               m_abort = 1;
            end else begin
               m_play_left--;
               if (m_play_left == 0) begin
                  m_mode = M_GAP;
                  m_gap_left = GAP;
                  nn = 0;
               end
            end
         end
         default: begin
            if (k != 0) begin
               m_mode = M_KEY;
               nn = k;
            end else begin
               m_gap_left--;
               if (m_gap_left == 0) m_mode = M_IDLE;
            end
         end
      endcase
      if (nn != m_note) m_age = 0;
      else m_age++;
      m_note = nn;
   endtask

   // Called at a falling edge; drives one cycle of inputs and checks the result.
   task automatic applyStimulus(input logic [6:0] k, input logic v, input logic [2:0] n,
                                input logic [3:0] b);
      key = k;
      seq_valid = v;
      seq_note = n;
      seq_beats = b;
      #1;
      checkOutput("seq_ready", int'(seq_ready), int'((m_mode == M_IDLE) && (k == 7'd0)));
      @(posedge clk_100mhz);
      modelStep();
      @(negedge clk_100mhz);
      checkOutput("cur_note", int'(cur_note), m_note);
      checkOutput("buzzer", int'(buzzer), expectedBuzzer());
      checkOutput("busy", int'(busy), int'(m_mode != M_IDLE));
      checkOutput("seq_abort", int'(seq_abort), m_abort);
   endtask

   task automatic holdInputs(input logic [6:0] k, input int cycles);
      for (int i = 0; i < cycles; i++) applyStimulus(k, 1'b0, 3'd0, 4'd0);
   endtask

   // Reset lands between clock edges so the outputs must clear asynchronously.
   task automatic doReset();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_seq_ready", int'(seq_ready), 0);
      checkOutput("rst_cur_note", int'(cur_note), 0);
      checkOutput("rst_buzzer", int'(buzzer), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_seq_abort", int'(seq_abort), 0);
      m_mode = M_IDLE;
      m_note = 0;
      m_age = 0;
      m_abort = 0;
      repeat (3) @(negedge clk_100mhz);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [6:0] rk;
      int hold;
      logic [3:0] rb;
      rk = 7'd0;
      hold = 0;
      @(negedge clk_100mhz);
      doReset();

      holdInputs(7'h20, 250);
      holdInputs(7'h00, 3);
      holdInputs(7'h05, 200);
      holdInputs(7'h04, 200);
      holdInputs(7'h00, 2);

      applyStimulus(7'h00, 1'b1, 3'd3, 4'd2);
      holdInputs(7'h00, 215);
      applyStimulus(7'h00, 1'b1, 3'd5, 4'd1);
      holdInputs(7'h00, 115);

      applyStimulus(7'h00, 1'b1, 3'd7, 4'd3);
      holdInputs(7'h00, 49);
      holdInputs(7'h01, 20);
      holdInputs(7'h00, 5);

      applyStimulus(7'h00, 1'b1, 3'd2, 4'd0);
      holdInputs(7'h00, 15);
      applyStimulus(7'h00, 1'b1, 3'd0, 4'd1);
      holdInputs(7'h00, 115);

      applyStimulus(7'h00, 1'b1, 3'd7, 4'd2);
      holdInputs(7'h00, 30);
      doReset();
      applyStimulus(7'h00, 1'b1, 3'd3, 4'd2);
      holdInputs(7'h00, 215);

      for (int c = 0; c < 20000; c++) begin
         if (hold == 0) begin
            hold = $urandom_range(1, 300);
            case ($urandom_range(0, 9))
               6, 7:    rk = 7'(1 << $urandom_range(0, 6));
               8, 9:    rk = 7'($urandom_range(1, 127));
               default: rk = 7'd0;
            endcase
         end
         hold--;
         if (c % 5000 == 2500) doReset();
         if ($urandom_range(0, 9) == 0) rb = 4'($urandom_range(0, 15));
         else rb = 4'($urandom_range(0, 3));
         applyStimulus(rk, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rb);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
